// File: rtl/defines.sv
// Shared widths and writeback types for the datapath.
package defines;

    localparam int WORD_LEN          = 32;
    localparam int REG_FILE_ADDR_LEN = 4;
    localparam int REG_FILE_SIZE     = 16;

    typedef struct packed {
        logic [REG_FILE_ADDR_LEN-1:0] dest;
        logic [WORD_LEN-1:0]          data;
    } wb_entry_t;

    typedef enum logic {
        WB_SRC_ALU = 1'b0,
        WB_SRC_LD  = 1'b1
    } wb_src_e;

endpackage

// File: rtl/wb_fifo.sv
// Shift-register FIFO: entries[0] is always the head, entries[i] valid while i < count.
module wb_fifo #(
    parameter int  DEPTH = 2,
    parameter type T     = logic,
    parameter int  CW    = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  T                data,
    input  logic            pop,
    output T                entries [DEPTH],
    output logic [CW-1:0]   count,
    output logic [DEPTH-1:0] valid
);

    T              mem_d [DEPTH];
    logic [CW-1:0] wr_idx;

    // Caller guarantees push only when not full and pop only when not empty.
    always_comb begin
        mem_d  = entries;
        wr_idx = count - CW'(pop);
        if (pop) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                mem_d[i] = entries[i + 1];
            end
        end
        if (push) begin
            mem_d[wr_idx] = data;
        end
    end

    always_ff @(posedge clk) begin
        entries <= mem_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else begin
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_comb begin
        valid = '0;
        for (int i = 0; i < DEPTH; i++) begin
            valid[i] = CW'(i) < count;
        end
    end

endmodule

// File: rtl/writeback_stage.sv
// Buffers ALU and load results and writes them to the register file one per cycle in arrival order.
module writeback_stage
    import defines::*;
#(
    parameter int ALU_DEPTH = 2,
    parameter int LD_DEPTH  = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         alu_valid,
    output logic                         alu_ready,
    input  logic [REG_FILE_ADDR_LEN-1:0] alu_dest,
    input  logic [WORD_LEN-1:0]          alu_data,
    input  logic                         ld_valid,
    output logic                         ld_ready,
    input  logic [REG_FILE_ADDR_LEN-1:0] ld_dest,
    input  logic [WORD_LEN-1:0]          ld_data,
    output logic                         wb_en,
    output logic [REG_FILE_ADDR_LEN-1:0] wb_dest,
    output logic [WORD_LEN-1:0]          wb_val,
    output logic [REG_FILE_SIZE-1:0]     pend_mask
);

    localparam int ACW       = $clog2(ALU_DEPTH + 1);
    localparam int LCW       = $clog2(LD_DEPTH + 1);
    localparam int ORD_DEPTH = ALU_DEPTH + LD_DEPTH;
    localparam int OCW       = $clog2(ORD_DEPTH + 1);

    wb_entry_t          alu_ent [ALU_DEPTH];
    wb_entry_t          ld_ent  [LD_DEPTH];
    logic [ACW-1:0]     alu_count;
    logic [LCW-1:0]     ld_count;
    logic [ALU_DEPTH-1:0] alu_vld;
    logic [LD_DEPTH-1:0]  ld_vld;
    logic               alu_push, ld_push, alu_pop, ld_pop;

    wb_src_e            ord_q [ORD_DEPTH];
    wb_src_e            ord_d [ORD_DEPTH];
    logic [OCW-1:0]     ord_count;
    logic [OCW-1:0]     ord_wr;
    logic               ord_pop;
    wb_entry_t          head;

    assign alu_ready = !rst && (alu_count < ACW'(ALU_DEPTH));
    assign ld_ready  = !rst && (ld_count < LCW'(LD_DEPTH));
    assign alu_push  = alu_valid && alu_ready;
    assign ld_push   = ld_valid && ld_ready;

    wb_fifo #(.DEPTH(ALU_DEPTH), .T(wb_entry_t)) u_alu_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (alu_push),
        .data    ({alu_dest, alu_data}),
        .pop     (alu_pop),
        .entries (alu_ent),
        .count   (alu_count),
        .valid   (alu_vld)
    );

    wb_fifo #(.DEPTH(LD_DEPTH), .T(wb_entry_t)) u_ld_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (ld_push),
        .data    ({ld_dest, ld_data}),
        .pop     (ld_pop),
        .entries (ld_ent),
        .count   (ld_count),
        .valid   (ld_vld)
    );

    // Order FIFO takes two tags per edge; the load goes in first because it is older.
    always_comb begin
        ord_d   = ord_q;
        ord_pop = ord_count != '0;
        if (ord_pop) begin
            for (int i = 0; i < ORD_DEPTH - 1; i++) begin
                ord_d[i] = ord_q[i + 1];
            end
        end
        ord_wr = ord_count - OCW'(ord_pop);
        if (ld_push) begin
            ord_d[ord_wr] = WB_SRC_LD;
            ord_wr        = ord_wr + 1'b1;
        end
        if (alu_push) begin
            ord_d[ord_wr] = WB_SRC_ALU;
        end
    end

    always_ff @(posedge clk) begin
        ord_q <= ord_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ord_count <= '0;
        end else begin
            ord_count <= ord_count + OCW'(ld_push) + OCW'(alu_push) - OCW'(ord_pop);
        end
    end

    assign alu_pop = ord_pop && (ord_q[0] == WB_SRC_ALU);
    assign ld_pop  = ord_pop && (ord_q[0] == WB_SRC_LD);
    assign head    = (ord_q[0] == WB_SRC_LD) ? ld_ent[0] : alu_ent[0];

    // r0 entries drain normally but never strobe, so the register file's r0 clear wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_en   <= 1'b0;
            wb_dest <= '0;
            wb_val  <= '0;
        end else if (ord_pop) begin
            wb_en   <= head.dest != '0;
            wb_dest <= head.dest;
            wb_val  <= head.data;
        end else begin
            wb_en   <= 1'b0;
        end
    end

    always_comb begin
        pend_mask = '0;
        for (int i = 0; i < ALU_DEPTH; i++) begin
            if (alu_vld[i]) pend_mask[alu_ent[i].dest] = 1'b1;
        end
        for (int i = 0; i < LD_DEPTH; i++) begin
            if (ld_vld[i]) pend_mask[ld_ent[i].dest] = 1'b1;
        end
        pend_mask[0] = 1'b0;
    end

endmodule
